// File: rtl/sensor_frame_packer.sv
// Packs I2C sensor bytes into frames and streams them out as A5, SEQ, payload[, CSUM].
// Define PACKER_CHECKSUM_EN to append the CSUM byte (SEQ + payload sum, mod 256).
module sensor_frame_packer #(
    parameter int FRAME_BYTES = 6
) (
    input  logic       CLK_48MHZ,
    input  logic       EXT_RESET,
    input  logic [7:0] BYTE_IN,
    input  logic       BYTE_VALID,
    input  logic       FRAME_START,
    output logic [7:0] OUT_DATA,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic       FRAME_ERR,
    output logic       OVERFLOW,
    output logic [7:0] DROP_CNT
);
    localparam int IW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BYTES - 1);
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef PACKER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, SYNC, SEQ, PAYLOAD, CSUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, SYNC, SEQ, PAYLOAD} state_t;
`endif

    state_t                       state_q, state_d;
    logic [FRAME_BYTES-1:0][7:0]  coll_q, coll_d;
    logic [FRAME_BYTES-1:0][7:0]  emit_q, emit_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic [IW-1:0]                pay_idx_q, pay_idx_d;
    logic [7:0]                   seq_q, seq_d;
    logic [7:0]                   out_data_q, out_data_d;
    logic                         out_valid_q, out_valid_d;
    logic                         frame_err_q, frame_err_d;
    logic                         overflow_q, overflow_d;
    logic [7:0]                   drop_cnt_q, drop_cnt_d;
`ifdef PACKER_CHECKSUM_EN
    logic [7:0]                   csum_q, csum_d;
`endif

    logic          xfer;
    logic          last_xfer;
    logic          frame_done;
    logic [IW-1:0] wr_idx;

    always_comb begin
        state_d     = state_q;
        coll_d      = coll_q;
        emit_d      = emit_q;
        idx_d       = idx_q;
        pay_idx_d   = pay_idx_q;
        seq_d       = seq_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        frame_err_d = 1'b0;
        overflow_d  = 1'b0;
        drop_cnt_d  = drop_cnt_q;
`ifdef PACKER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        xfer        = out_valid_q && OUT_READY;
        last_xfer   = 1'b0;
        frame_done  = 1'b0;
        // A coincident FRAME_START restarts the frame before the byte lands.
        wr_idx      = FRAME_START ? '0 : idx_q;

        if (FRAME_START) begin
            idx_d       = '0;
            frame_err_d = (idx_q != '0);
        end
        if (BYTE_VALID) begin
            coll_d[wr_idx] = BYTE_IN;
            if (wr_idx == LAST_IDX) begin
                frame_done = 1'b1;
                idx_d      = '0;
            end else begin
                idx_d = wr_idx + 1'b1;
            end
        end

        if (xfer) begin
            case (state_q)
                SYNC: begin
                    state_d    = SEQ;
                    out_data_d = seq_q;
                end
                SEQ: begin
                    state_d    = PAYLOAD;
                    pay_idx_d  = '0;
                    out_data_d = emit_q[0];
`ifdef PACKER_CHECKSUM_EN
                    csum_d     = seq_q;
`endif
                end
                PAYLOAD: begin
`ifdef PACKER_CHECKSUM_EN
                    csum_d = csum_q + out_data_q;
`endif
                    if (pay_idx_q == LAST_IDX) begin
`ifdef PACKER_CHECKSUM_EN
                        state_d    = CSUM;
                        out_data_d = csum_q + out_data_q;
`else
                        last_xfer  = 1'b1;
`endif
                    end else begin
                        pay_idx_d  = pay_idx_q + 1'b1;
                        out_data_d = emit_q[pay_idx_q + 1'b1];
                    end
                end
`ifdef PACKER_CHECKSUM_EN
                CSUM: last_xfer = 1'b1;
`endif
                default: ;
            endcase
        end

        if (last_xfer) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_data_d  = 8'h00;
            seq_d       = seq_q + 8'd1;
        end

        // The emit buffer can take a new frame only if it is free by the end of this cycle.
        if (frame_done) begin
            if (state_q == IDLE || last_xfer) begin
                emit_d      = coll_d;
                state_d     = SYNC;
                out_valid_d = 1'b1;
                out_data_d  = SYNC_BYTE;
                pay_idx_d   = '0;
            end else begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 8'hFF)
                    drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK_48MHZ or posedge EXT_RESET) begin
        if (EXT_RESET) begin
            state_q     <= IDLE;
            coll_q      <= '0;
            emit_q      <= '0;
            idx_q       <= '0;
            pay_idx_q   <= '0;
            seq_q       <= 8'h00;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= 8'h00;
`ifdef PACKER_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            coll_q      <= coll_d;
            emit_q      <= emit_d;
            idx_q       <= idx_d;
            pay_idx_q   <= pay_idx_d;
            seq_q       <= seq_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
`ifdef PACKER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign OUT_DATA  = out_data_q;
    assign OUT_VALID = out_valid_q;
    assign FRAME_ERR = frame_err_q;
    assign OVERFLOW  = overflow_q;
    assign DROP_CNT  = drop_cnt_q;

endmodule

// File: tb/tb_sensor_frame_packer.sv
// Self-checking bench for sensor_frame_packer: directed scenarios plus random traffic
// compared each cycle against a queue-based frame model.
module tb_sensor_frame_packer;
    localparam int FB = 6;

    logic       clk = 1'b0;
    logic       EXT_RESET = 1'b1;
    logic [7:0] BYTE_IN = 8'h00;
    logic       BYTE_VALID = 1'b0;
    logic       FRAME_START = 1'b0;
    logic       OUT_READY = 1'b0;
    logic [7:0] OUT_DATA;
    logic       OUT_VALID;
    logic       FRAME_ERR;
    logic       OVERFLOW;
    logic [7:0] DROP_CNT;

    sensor_frame_packer #(.FRAME_BYTES(FB)) dut (
        .CLK_48MHZ  (clk),
        .EXT_RESET  (EXT_RESET),
        .BYTE_IN    (BYTE_IN),
        .BYTE_VALID (BYTE_VALID),
        .FRAME_START(FRAME_START),
        .OUT_DATA   (OUT_DATA),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .FRAME_ERR  (FRAME_ERR),
        .OVERFLOW   (OVERFLOW),
        .DROP_CNT   (DROP_CNT)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int err_seen = 0;
    int ovf_seen = 0;

    // Reference model: frames in flight as a byte queue, collected bytes as a list.
    logic [7:0] mq[$];
    logic [7:0] mcoll[$];
    logic [7:0] log_q[$];
    bit [7:0]   mseq = 0;
    int         mdrop = 0;
    bit         exp_err = 0;
    bit         exp_ovf = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mcoll.delete();
        mseq = 0;
        mdrop = 0;
        exp_err = 0;
        exp_ovf = 0;
    endtask

    task automatic model_edge(input bit fs, input bit bv, input logic [7:0] b, input bit rdy);
        bit idle0, fin;
        int s;
        idle0 = (mq.size() == 0);
        fin = 0;
        exp_err = 0;
        exp_ovf = 0;
        if (!idle0 && rdy) begin
            void'(mq.pop_front());
            if (mq.size() == 0) begin
                fin = 1;
                mseq++;
            end
        end
        if (fs) begin
            if (mcoll.size() != 0) exp_err = 1;
            mcoll.delete();
        end
        if (bv) begin
            mcoll.push_back(b);
            if (mcoll.size() == FB) begin
                if (idle0 || fin) begin
                    s = mseq;
                    mq.push_back(8'hA5);
                    mq.push_back(mseq);
                    foreach (mcoll[i]) begin
                        mq.push_back(mcoll[i]);
                        s += mcoll[i];
                    end
`ifdef PACKER_CHECKSUM_EN
                    mq.push_back(s[7:0]);
`endif
                end else begin
                    exp_ovf = 1;
                    if (mdrop < 255) mdrop++;
                end
                mcoll.delete();
            end
        end
    endtask

    task automatic step(input bit fs, input bit bv, input logic [7:0] b, input bit rdy);
        logic [7:0] held;
        bit stall;
        bit ev;
        @(negedge clk);
        FRAME_START = fs;
        BYTE_VALID = bv;
        BYTE_IN = b;
        OUT_READY = rdy;
        if (OUT_VALID && rdy) log_q.push_back(OUT_DATA);
        stall = OUT_VALID && !rdy;
        held = OUT_DATA;
        @(posedge clk);
        model_edge(fs, bv, b, rdy);
        #1;
        cyc++;
        if (stall) chk("stall_hold", OUT_DATA, held);
        ev = (mq.size() > 0);
        chk("out_valid", OUT_VALID, ev);
        if (ev) chk("out_data", OUT_DATA, mq[0]);
        chk("frame_err", FRAME_ERR, exp_err);
        chk("overflow", OVERFLOW, exp_ovf);
        chk("drop_cnt", DROP_CNT, mdrop);
        if (FRAME_ERR) err_seen++;
        if (OVERFLOW) ovf_seen++;
    endtask

    function automatic bit rdy_of(input int mode);
        return (mode == 1) ? 1'b1 : (mode == 2) ? bit'(cyc[0]) : 1'b0;
    endfunction

    task automatic send(input bit fs, input logic [7:0] bytes[$], input int mode);
        if (fs) step(1, 0, 8'h00, rdy_of(mode));
        foreach (bytes[i]) step(0, 1, bytes[i], rdy_of(mode));
    endtask

    task automatic drain(input int mode);
        for (int i = 0; i < 200 && mq.size() > 0; i++) step(0, 0, 8'h00, rdy_of(mode));
        step(0, 0, 8'h00, rdy_of(mode));
        chk("drain_idle", OUT_VALID, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        EXT_RESET = 1;
        FRAME_START = 0;
        BYTE_VALID = 0;
        OUT_READY = 0;
        #1;
        chk("rst_valid", OUT_VALID, 0);
        chk("rst_data", OUT_DATA, 0);
        chk("rst_err", FRAME_ERR, 0);
        chk("rst_ovf", OVERFLOW, 0);
        chk("rst_drop", DROP_CNT, 0);
        model_reset();
        @(posedge clk);
        #1;
        @(negedge clk);
        EXT_RESET = 0;
    endtask

    task automatic cmp_log(input string tag, input logic [7:0] exp[$]);
        chk({tag, "_len"}, log_q.size(), exp.size());
        foreach (exp[i]) if (i < log_q.size()) chk({tag, "_byte"}, log_q[i], exp[i]);
    endtask

    initial begin
        logic [7:0] pay[$];
        logic [7:0] basic[$];
        logic [7:0] second[$];
        logic [7:0] part[$];
        logic [7:0] rp[$];

        pay    = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        basic  = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        second = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
`ifdef PACKER_CHECKSUM_EN
        basic.push_back(8'h15);
        second.push_back(8'h16);
`endif
        part = '{8'h11, 8'h22, 8'h33};

        // Basic frame with explicit first-valid latency.
        do_reset();
        log_q.delete();
        step(1, 0, 8'h00, 1);
        for (int i = 0; i < FB - 1; i++) step(0, 1, pay[i], 1);
        chk("pre_valid", OUT_VALID, 0);
        step(0, 1, pay[FB-1], 1);
        chk("first_valid", OUT_VALID, 1);
        chk("first_data", OUT_DATA, 8'hA5);
        drain(1);
        cmp_log("basic", basic);

        // Second frame carries SEQ 01.
        log_q.delete();
        send(1, pay, 1);
        drain(1);
        cmp_log("second", second);

        // Back-pressure toggling every cycle.
        do_reset();
        log_q.delete();
        send(1, pay, 2);
        drain(2);
        cmp_log("bp", basic);

        // Partial frame discarded.
        do_reset();
        log_q.delete();
        err_seen = 0;
        send(1, part, 1);
        send(1, pay, 1);
        drain(1);
        chk("partial_err_pulses", err_seen, 1);
        cmp_log("partial", basic);

        // Overflow with downstream stalled.
        do_reset();
        log_q.delete();
        ovf_seen = 0;
        send(1, pay, 0);
        send(1, pay, 0);
        chk("ovf_pulses", ovf_seen, 1);
        chk("ovf_drop_cnt", DROP_CNT, 1);
        drain(1);
        cmp_log("ovf", basic);

        // Reset mid-emission after four bytes.
        do_reset();
        log_q.delete();
        send(1, pay, 1);
        for (int i = 0; i < 20 && log_q.size() < 4; i++) step(0, 0, 8'h00, 1);
        chk("mid_emit_bytes", log_q.size(), 4);
        do_reset();
        log_q.delete();
        send(1, pay, 1);
        drain(1);
        cmp_log("post_rst", basic);

        // Reset mid-collection: next bytes start at index 0 without FRAME_START.
        do_reset();
        send(0, part, 1);
        do_reset();
        log_q.delete();
        err_seen = 0;
        send(0, pay, 1);
        drain(1);
        chk("midcol_err", err_seen, 0);
        cmp_log("midcol", basic);

        // SEQ wraps after 256 frames.
        do_reset();
        for (int f = 0; f < 256; f++) begin
            rp.delete();
            for (int i = 0; i < FB; i++) rp.push_back(8'($urandom));
            send(1, rp, 1);
            drain(1);
        end
        log_q.delete();
        send(1, pay, 1);
        drain(1);
        cmp_log("wrap", basic);

        // DROP_CNT saturation.
        do_reset();
        for (int i = 0; i < FB * 260; i++) step(0, 1, 8'($urandom), 0);
        chk("drop_sat", DROP_CNT, 255);
        drain(1);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 19) == 0, 1'($urandom), 8'($urandom), $urandom_range(0, 3) != 0);
        drain(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sensor_frame_packer.md
SENSOR_FRAME_PACKER -- requirements
Module: sensor_frame_packer

Interface
REQ-001 Parameter FRAME_BYTES, default 6: payload bytes per sensor sample; legal range 1..16.
REQ-002 Port CLK_48MHZ  in  1  system clock, 48 MHz; all state changes on its rising edge.
REQ-003 Port EXT_RESET  in  1  reset, asynchronous, active-high.
REQ-004 Port BYTE_IN  in  8  data byte received from the I2C read engine.
REQ-005 Port BYTE_VALID  in  1  one-cycle strobe qualifying BYTE_IN.
REQ-006 Port FRAME_START  in  1  one-cycle strobe from the I2C engine marking the start of a new sensor read transaction.
REQ-007 Port OUT_DATA  out  8  framed byte stream to the telemetry stage.
REQ-008 Port OUT_VALID  out  1  OUT_DATA holds a valid byte.
REQ-009 Port OUT_READY  in  1  downstream accepts the byte.
REQ-010 Port FRAME_ERR  out  1  one-cycle pulse: a partial frame was discarded.
REQ-011 Port OVERFLOW  out  1  one-cycle pulse: a complete frame was dropped.
REQ-012 Port DROP_CNT  out  8  count of dropped frames, saturating at 255.

Function
REQ-013 The block SHALL keep two buffers: a collect buffer of FRAME_BYTES bytes with a write index, and an emit buffer.
REQ-014 Each BYTE_VALID SHALL write BYTE_IN to the collect buffer at the current index and increment the index.
REQ-015 FRAME_START SHALL clear the index; if the index was nonzero, FRAME_ERR SHALL pulse for one cycle.
REQ-016 When FRAME_START and BYTE_VALID coincide, FRAME_START SHALL act first, and the byte SHALL be stored at index 0.
REQ-017 On the cycle the byte at index FRAME_BYTES-1 is written, the frame SHALL complete and the index SHALL return to 0.
REQ-018 A completed frame SHALL be committed to the emit buffer if the emitter is idle, or if the emitter's final byte transfers in that same cycle.
REQ-019 If neither condition of REQ-018 holds, the frame SHALL be dropped, OVERFLOW SHALL pulse, DROP_CNT SHALL increment (saturating), and the sequence number SHALL be unchanged.
REQ-020 The emitter FSM states SHALL be IDLE, SYNC, SEQ, PAYLOAD, CSUM.
- Commit: IDLE->SYNC.
- A state SHALL advance only on a cycle with OUT_VALID=1 and OUT_READY=1.
- SYNC->SEQ->PAYLOAD; PAYLOAD loops FRAME_BYTES times; then ->CSUM->IDLE (or ->SYNC if a commit occurs in the same cycle).
REQ-021 Emitted bytes SHALL be, in order: 0xA5, SEQ, payload[0..FRAME_BYTES-1], CSUM.
- SEQ: 8-bit frame counter.
- CSUM: (SEQ + sum of payload bytes) mod 256.
REQ-022 OUT_VALID SHALL rise on the cycle after the commit edge, so the completing BYTE_VALID edge plus one cycle gives the first byte.
REQ-023 OUT_VALID SHALL stay high from SYNC through CSUM with no gaps when OUT_READY is held high.
REQ-024 OUT_DATA SHALL be stable while OUT_VALID=1 and OUT_READY=0.
REQ-025 SEQ SHALL increment after each frame's CSUM transfer and wrap from 255 to 0.
REQ-026 Input SHALL never be back-pressured; bytes arriving while the emitter is busy SHALL still be collected.

Reset
REQ-027 Asserting EXT_RESET SHALL immediately force the following, regardless of the clock:
- emitter to IDLE;
- collect index, SEQ and DROP_CNT to 0;
- OUT_DATA to 0x00;
- OUT_VALID, FRAME_ERR and OVERFLOW to 0.
REQ-028 Reset mid-frame SHALL discard both buffers without asserting FRAME_ERR or OVERFLOW.
REQ-029 The first BYTE_VALID after reset release SHALL be stored at index 0.

Configuration
REQ-030 Macro PACKER_CHECKSUM_EN defined: frames SHALL include CSUM, giving FRAME_BYTES+3 bytes.
REQ-031 Macro undefined: the CSUM state and adder SHALL be omitted, frames SHALL be FRAME_BYTES+2 bytes, and PAYLOAD SHALL go directly to IDLE; all other behaviour is unchanged.

Verification
REQ-032 Basic frame: with the macro defined, FRAME_START, then bytes 01..06, OUT_READY=1 -> bench sees A5 00 01 02 03 04 05 06 15; OUT_VALID is first high 1 cycle after the byte-06 edge.
REQ-033 Second frame with the same payload -> A5 01 01 02 03 04 05 06 16; after 256 frames, SEQ returns to 00.
REQ-034 Back-pressure: with OUT_READY toggling 1/0 every cycle, the byte sequence is identical to REQ-032 and OUT_DATA is held during every stall.
REQ-035 Partial frame: FRAME_START, bytes 11 22 33, FRAME_START, bytes 01..06 -> FRAME_ERR pulses once, and the emitted frame is the REQ-032 frame.
REQ-036 Overflow: with OUT_READY=0, complete two frames -> the second is dropped, OVERFLOW pulses once, DROP_CNT=1; releasing OUT_READY emits only frame one, with SEQ 00.
REQ-037 Reset mid-emission after 4 bytes -> OUT_VALID=0 immediately; the next frame emits with SEQ 00; without the macro, the REQ-032 stimulus yields 8 bytes with no 15.
